// File: rtl/ep_issue_ctrl.sv
// ---------------------------------------------------------------------------
// ep_issue_ctrl -- even-pipe issue controller
//
// Holds one decoded instruction and issues it to the even pipe once it is
// free of RAW hazards against in-flight results and its writeback cycle does
// not collide with an in-flight result. Every issued instruction that writes
// a register is tracked in a slot until its result reaches writeback.
//
// Optional feature macro: EP_ISSUE_STATS_EN
//   defined   -> stall_count counts held, non-issuing cycles (saturating)
//   undefined -> stall_count is tied to 0 and has no flop
//
// Parameters
//   MAX_LAT    largest accepted latency, 2..7
//   NUM_SLOTS  in-flight tracker entries, >= MAX_LAT
//
// Ports
//   clock, reset                 clock, async active-low reset
//   dec_valid / dec_ready        decode handshake
//   dec_op_code                  operation from decode
//   ra/rb/rc_addr_input          source addresses, src_use_input enables
//   rt_address_input             destination, wrt_en_input its enable
//   lat_input                    operation latency
//   flush                        discard the held instruction
//   ep_issue, ep_*               registered issue strobe and fields
//   wb_valid, wb_address         tracked result at writeback this cycle
//   stall_count                  held, non-issuing cycle counter
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package ep_issue_pkg;
   typedef enum logic [3:0] {
      NOP               = 4'd0,
      ADD_WORD          = 4'd1,
      AND_WORD          = 4'd2,
      MULTIPLY          = 4'd3,
      FLOATING_MULTIPLY = 4'd4
   } opcode_t;
endpackage

module ep_issue_ctrl
   import ep_issue_pkg::*;
#(
   parameter int MAX_LAT   = 7,
   parameter int NUM_SLOTS = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          dec_valid,
   output logic          dec_ready,
   input  opcode_t       dec_op_code,
   input  logic [6:0]    ra_addr_input,
   input  logic [6:0]    rb_addr_input,
   input  logic [6:0]    rc_addr_input,
   input  logic [0:2]    src_use_input,
   input  logic [6:0]    rt_address_input,
   input  logic          wrt_en_input,
   input  logic [0:2]    lat_input,
   input  logic          flush,
   output logic          ep_issue,
   output opcode_t       ep_op_code,
   output logic [6:0]    ep_ra_addr,
   output logic [6:0]    ep_rb_addr,
   output logic [6:0]    ep_rc_addr,
   output logic [6:0]    ep_rt_address,
   output logic          ep_wrt_en,
   output logic          wb_valid,
   output logic [6:0]    wb_address,
   output logic [0:31]   stall_count
);

   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   if (MAX_LAT < 2 || MAX_LAT > 7) begin : g_bad_lat
      $error("ep_issue_ctrl: MAX_LAT must be within 2..7");
   end
   if (NUM_SLOTS < MAX_LAT) begin : g_bad_slots
      $error("ep_issue_ctrl: NUM_SLOTS must be at least MAX_LAT");
   end

   // hold register
   logic          h_v;
   opcode_t       h_op;
   logic [6:0]    h_ra;
   logic [6:0]    h_rb;
   logic [6:0]    h_rc;
   logic [0:2]    h_use;
   logic [6:0]    h_rt;
   logic          h_wen;
   logic [2:0]    h_lat;

   // tracker slots
   logic [NUM_SLOTS-1:0] s_v;
   logic [6:0]           s_rt  [NUM_SLOTS];
   logic [2:0]           s_cnt [NUM_SLOTS];

   logic             hazard;
   logic             collide;
   logic             issue_now;
   logic             alloc;
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic [2:0]       lat_eff;

   // Out-of-range latencies are clamped once, at load, so the hold register
   // always carries the latency actually used for tracking and collisions.
   always_comb begin
      lat_eff = 3'(MAX_LAT);
      if (lat_input >= 3'd2 && lat_input <= 3'(MAX_LAT)) begin
         lat_eff = lat_input;
      end
   end

   // Hazard, collision and writeback decode over all slots. A slot at count 1
   // writes back this cycle, so a consumer may issue alongside it. Slot counts
   // are unique because of the collision check, hence at most one writeback.
   always_comb begin
      hazard     = 1'b0;
      collide    = 1'b0;
      wb_valid   = 1'b0;
      wb_address = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (s_v[i] && s_cnt[i] > 3'd1) begin
            if (h_use[0] && h_ra == s_rt[i]) hazard = 1'b1;
            if (h_use[1] && h_rb == s_rt[i]) hazard = 1'b1;
            if (h_use[2] && h_rc == s_rt[i]) hazard = 1'b1;
         end
         if (s_v[i] && h_wen && (s_cnt[i] - 3'd1) == h_lat) begin
            collide = 1'b1;
         end
         if (s_v[i] && s_cnt[i] == 3'd1) begin
            wb_valid   = 1'b1;
            wb_address = wb_address | s_rt[i];
         end
      end
   end

   assign issue_now = h_v && !hazard && !collide && !flush;
   assign dec_ready = !h_v || issue_now;

   // A slot at count 1 retires on this edge, so it can be reused immediately;
   // this keeps NUM_SLOTS == MAX_LAT sufficient for back-to-back issue.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!free_found && (!s_v[i] || s_cnt[i] == 3'd1)) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign alloc = issue_now && h_wen && free_found;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         h_v   <= 1'b0;
         h_op  <= NOP;
         h_ra  <= '0;
         h_rb  <= '0;
         h_rc  <= '0;
         h_use <= '0;
         h_rt  <= '0;
         h_wen <= 1'b0;
         h_lat <= '0;
      end else if (flush) begin
         h_v <= 1'b0;
      end else if (dec_valid && dec_ready) begin
         h_v   <= 1'b1;
         h_op  <= dec_op_code;
         h_ra  <= ra_addr_input;
         h_rb  <= rb_addr_input;
         h_rc  <= rc_addr_input;
         h_use <= src_use_input;
         h_rt  <= rt_address_input;
         h_wen <= wrt_en_input;
         h_lat <= lat_eff;
      end else if (issue_now) begin
         h_v <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s_v <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            s_rt[i]  <= '0;
            s_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (alloc && free_idx == IDX_W'(i)) begin
               s_v[i]   <= 1'b1;
               s_rt[i]  <= h_rt;
               s_cnt[i] <= h_lat;
            end else if (s_v[i]) begin
               s_cnt[i] <= s_cnt[i] - 3'd1;
               if (s_cnt[i] == 3'd1) s_v[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ep_issue      <= 1'b0;
         ep_op_code    <= NOP;
         ep_ra_addr    <= '0;
         ep_rb_addr    <= '0;
         ep_rc_addr    <= '0;
         ep_rt_address <= '0;
         ep_wrt_en     <= 1'b0;
      end else begin
         ep_issue  <= issue_now;
         ep_wrt_en <= issue_now && h_wen;
         if (issue_now) begin
            ep_op_code    <= h_op;
            ep_ra_addr    <= h_ra;
            ep_rb_addr    <= h_rb;
            ep_rc_addr    <= h_rc;
            ep_rt_address <= h_rt;
         end
      end
   end

`ifdef EP_ISSUE_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
      end else if (h_v && !issue_now && !flush && stall_count != '1) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_ep_issue_ctrl.sv
`timescale 1ns/1ps

module tb_ep_issue_ctrl;
   import ep_issue_pkg::*;

`ifdef EP_ISSUE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clock;
   logic          reset;
   logic          dec_valid;
   logic          dec_ready;
   opcode_t       dec_op_code;
   logic [6:0]    ra_addr_input;
   logic [6:0]    rb_addr_input;
   logic [6:0]    rc_addr_input;
   logic [0:2]    src_use_input;
   logic [6:0]    rt_address_input;
   logic          wrt_en_input;
   logic [0:2]    lat_input;
   logic          flush;
   logic          ep_issue;
   opcode_t       ep_op_code;
   logic [6:0]    ep_ra_addr;
   logic [6:0]    ep_rb_addr;
   logic [6:0]    ep_rc_addr;
   logic [6:0]    ep_rt_address;
   logic          ep_wrt_en;
   logic          wb_valid;
   logic [6:0]    wb_address;
   logic [0:31]   stall_count;

   ep_issue_ctrl #(.MAX_LAT(7), .NUM_SLOTS(8)) dut (
      .clock            (clock),
      .reset            (reset),
      .dec_valid        (dec_valid),
      .dec_ready        (dec_ready),
      .dec_op_code      (dec_op_code),
      .ra_addr_input    (ra_addr_input),
      .rb_addr_input    (rb_addr_input),
      .rc_addr_input    (rc_addr_input),
      .src_use_input    (src_use_input),
      .rt_address_input (rt_address_input),
      .wrt_en_input     (wrt_en_input),
      .lat_input        (lat_input),
      .flush            (flush),
      .ep_issue         (ep_issue),
      .ep_op_code       (ep_op_code),
      .ep_ra_addr       (ep_ra_addr),
      .ep_rb_addr       (ep_rb_addr),
      .ep_rc_addr       (ep_rc_addr),
      .ep_rt_address    (ep_rt_address),
      .ep_wrt_en        (ep_wrt_en),
      .wb_valid         (wb_valid),
      .wb_address       (wb_address),
      .stall_count      (stall_count)
   );

   typedef struct {
      opcode_t    op;
      logic [6:0] ra;
      logic [6:0] rt;
      logic       wen;
      int         cyc;
   } iss_t;

   typedef struct {
      logic [6:0] rt;
      int         cyc;
   } wb_t;

   iss_t iss_q[$];
   wb_t  wb_q[$];

   int n_chk     = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int exp_stall = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: every issue and writeback the DUT presents is matched against
   // the oldest expectation queued by the stimulus.
   always @(negedge clock) begin
      iss_t ie;
      wb_t  we;
      if (ep_issue) begin
         n_chk++;
         if (iss_q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got op=%0d rt=%0d at cycle %0d, required no issue",
                     ep_op_code, ep_rt_address, cyc);
         end else begin
            ie = iss_q.pop_front();
            if (ep_op_code != ie.op || ep_ra_addr != ie.ra || ep_rt_address != ie.rt ||
                ep_wrt_en != ie.wen || cyc != ie.cyc) begin
               n_fail++;
               $display("FAIL issue: got op=%0d ra=%0d rt=%0d wen=%0d cyc=%0d, required op=%0d ra=%0d rt=%0d wen=%0d cyc=%0d",
                        ep_op_code, ep_ra_addr, ep_rt_address, ep_wrt_en, cyc,
                        ie.op, ie.ra, ie.rt, ie.wen, ie.cyc);
            end
         end
      end
      if (wb_valid) begin
         n_chk++;
         if (wb_q.size() == 0) begin
            n_fail++;
            $display("FAIL wb_unexpected: got rt=%0d at cycle %0d, required no writeback",
                     wb_address, cyc);
         end else begin
            we = wb_q.pop_front();
            if (wb_address != we.rt || cyc != we.cyc) begin
               n_fail++;
               $display("FAIL wb: got rt=%0d cyc=%0d, required rt=%0d cyc=%0d",
                        wb_address, cyc, we.rt, we.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Present one instruction, wait (bounded) for acceptance, then queue the
   // expected issue (delay = stall cycles after the earliest issue edge, -1 =
   // never seen) and, if exp_wb, the expected writeback.
   task automatic send(input opcode_t op, input logic [6:0] ra, input logic [6:0] rb,
                       input logic [6:0] rc, input logic [2:0] use_s, input logic [6:0] rt,
                       input logic wen, input logic [2:0] lat, input int delay,
                       input bit exp_wb);
      int   n;
      int   acc;
      int   le;
      iss_t ie;
      wb_t  we;
      dec_op_code      = op;
      ra_addr_input    = ra;
      rb_addr_input    = rb;
      rc_addr_input    = rc;
      src_use_input    = use_s;
      rt_address_input = rt;
      wrt_en_input     = wen;
      lat_input        = lat;
      dec_valid        = 1'b1;
      n = 0;
      while (!dec_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      n_chk++;
      if (n >= 50) begin
         n_fail++;
         $display("FAIL accept_timeout: got no dec_ready in %0d cycles, required acceptance", n);
         dec_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      dec_valid = 1'b0;
      acc = cyc;
      le = (lat < 3'd2 || lat > 3'd7) ? 7 : int'(lat);
      if (delay >= 0) begin
         ie.op  = op;
         ie.ra  = ra;
         ie.rt  = rt;
         ie.wen = wen;
         ie.cyc = acc + 1 + delay;
         iss_q.push_back(ie);
         if (wen && exp_wb) begin
            we.rt  = rt;
            we.cyc = ie.cyc + le - 1;
            wb_q.push_back(we);
         end
      end
   endtask

   task automatic drain();
      repeat (10) @(posedge clock);
      #1;
   endtask

   task automatic chk_stall(input string name);
      chk(name, 32'(stall_count), STATS ? 32'(exp_stall) : 32'd0);
   endtask

   initial begin
      reset            = 1'b0;
      dec_valid        = 1'b0;
      dec_op_code      = NOP;
      ra_addr_input    = '0;
      rb_addr_input    = '0;
      rc_addr_input    = '0;
      src_use_input    = '0;
      rt_address_input = '0;
      wrt_en_input     = 1'b0;
      lat_input        = '0;
      flush            = 1'b0;

      repeat (2) @(posedge clock);
      #1;
      chk("rst_ep_issue",    32'(ep_issue),      32'd0);
      chk("rst_wb_valid",    32'(wb_valid),      32'd0);
      chk("rst_stall",       32'(stall_count),   32'd0);
      chk("rst_rt_addr",     32'(ep_rt_address), 32'd0);
      chk("rst_dec_ready",   32'(dec_ready),     32'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // independent lat=2 ops back to back
      send(ADD_WORD, 7'd20, 7'd0, 7'd0, 3'b100, 7'd1, 1'b1, 3'd2, 0, 1'b1);
      send(AND_WORD, 7'd21, 7'd0, 7'd0, 3'b100, 7'd2, 1'b1, 3'd2, 0, 1'b1);
      send(ADD_WORD, 7'd22, 7'd0, 7'd0, 3'b100, 7'd4, 1'b1, 3'd2, 0, 1'b1);
      drain();
      chk_stall("b2b_stall");

      // RAW on ra: ADD rt=3 lat=2, then AND ra=3 -> one bubble
      send(ADD_WORD, 7'd0, 7'd0, 7'd0, 3'b000, 7'd3, 1'b1, 3'd2, 0, 1'b1);
      send(AND_WORD, 7'd3, 7'd0, 7'd0, 3'b100, 7'd6, 1'b1, 3'd2, 1, 1'b1);
      exp_stall += 1;
      drain();
      chk_stall("raw_ra_stall");

      // writeback collision: FMUL lat=6 rt=5 then MULTIPLY lat=5 rt=9
      send(FLOATING_MULTIPLY, 7'd0, 7'd0, 7'd0, 3'b000, 7'd5, 1'b1, 3'd6, 0, 1'b1);
      send(MULTIPLY,          7'd0, 7'd0, 7'd0, 3'b000, 7'd9, 1'b1, 3'd5, 1, 1'b1);
      exp_stall += 1;
      drain();
      chk_stall("collide_stall");

      // RAW on rc only: enabled rc stalls until producer count reaches 1
      send(ADD_WORD, 7'd0,  7'd0,  7'd0,  3'b000, 7'd12, 1'b1, 3'd3, 0, 1'b1);
      send(AND_WORD, 7'd30, 7'd31, 7'd12, 3'b001, 7'd13, 1'b1, 3'd4, 2, 1'b1);
      exp_stall += 2;
      drain();
      chk_stall("raw_rc_stall");

      // same pair with all sources disabled -> no stall
      send(ADD_WORD, 7'd0,  7'd0,  7'd0,  3'b000, 7'd12, 1'b1, 3'd3, 0, 1'b1);
      send(AND_WORD, 7'd12, 7'd12, 7'd12, 3'b000, 7'd13, 1'b1, 3'd4, 0, 1'b1);
      drain();
      chk_stall("nouse_stall");

      // wrt_en=0 is exempt from the collision check and is not tracked
      send(FLOATING_MULTIPLY, 7'd0, 7'd0, 7'd0, 3'b000, 7'd7,  1'b1, 3'd3, 0, 1'b1);
      send(ADD_WORD,          7'd0, 7'd0, 7'd0, 3'b000, 7'd40, 1'b0, 3'd2, 0, 1'b1);
      drain();

      // out-of-range latency is treated as MAX_LAT
      send(ADD_WORD, 7'd0, 7'd0, 7'd0, 3'b000, 7'd8,  1'b1, 3'd1, 0, 1'b1);
      drain();
      send(ADD_WORD, 7'd0, 7'd0, 7'd0, 3'b000, 7'd10, 1'b1, 3'd0, 0, 1'b1);
      drain();
      chk_stall("lat_clamp_stall");

      // flush of a stalled instruction; producer still writes back
      send(ADD_WORD, 7'd0,  7'd0, 7'd0, 3'b000, 7'd14, 1'b1, 3'd4, 0, 1'b1);
      send(AND_WORD, 7'd14, 7'd0, 7'd0, 3'b100, 7'd15, 1'b1, 3'd2, -1, 1'b0);
      @(posedge clock);
      #1;
      exp_stall += 1;
      flush = 1'b1;
      chk("flush_ready_held", 32'(dec_ready), 32'd0);
      @(posedge clock);
      #1;
      flush = 1'b0;
      chk("flush_ready_after", 32'(dec_ready), 32'd1);
      chk("flush_no_issue",    32'(ep_issue),  32'd0);
      drain();
      chk_stall("flush_stall");

      // reset mid-stall with three results in flight
      send(FLOATING_MULTIPLY, 7'd0,  7'd0, 7'd0, 3'b000, 7'd20, 1'b1, 3'd7, 0, 1'b0);
      send(MULTIPLY,          7'd0,  7'd0, 7'd0, 3'b000, 7'd21, 1'b1, 3'd5, 0, 1'b0);
      send(ADD_WORD,          7'd0,  7'd0, 7'd0, 3'b000, 7'd22, 1'b1, 3'd2, -1, 1'b0);
      send(AND_WORD,          7'd20, 7'd0, 7'd0, 3'b100, 7'd23, 1'b1, 3'd2, -1, 1'b0);
      reset = 1'b0;
      #1;
      chk("mid_rst_ep_issue",  32'(ep_issue),      32'd0);
      chk("mid_rst_wrt_en",    32'(ep_wrt_en),     32'd0);
      chk("mid_rst_rt_addr",   32'(ep_rt_address), 32'd0);
      chk("mid_rst_ra_addr",   32'(ep_ra_addr),    32'd0);
      chk("mid_rst_wb_valid",  32'(wb_valid),      32'd0);
      chk("mid_rst_stall",     32'(stall_count),   32'd0);
      chk("mid_rst_dec_ready", 32'(dec_ready),     32'd1);
      exp_stall = 0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (12) @(posedge clock);
      #1;
      chk("post_rst_ready", 32'(dec_ready), 32'd1);
      chk_stall("post_rst_stall");

      chk("issue_queue_left", 32'(iss_q.size()), 32'd0);
      chk("wb_queue_left",    32'(wb_q.size()),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
